pwm_audio_out: RTL and testbench

Output stage placed directly after the chord mixer. It takes the mixer's 8-bit `sound` sample and a `gate` flag that is high while any key is held. It applies a 4-bit attack/release envelope so key transitions do not click, and drives a single-bit PWM pin for an external RC filter and speaker. Samples are taken once per PWM frame, so `sound` may change at any time without glitching the output.

---
 rtl/pwm_audio_if.sv | 36 +++
 rtl/pwm_audio_out.sv | 156 +++++++++++++++
 tb/tb_pwm_audio_out.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_audio_if.sv
// pwm_audio_if
//   Bundles the signals between the chord-mixer side and the PWM audio
//   output stage.
//   master : drives sound/gate, observes pwm_out/frame_start/env (mixer or bench)
//   slave  : the output stage itself
//   Signals:
//     sound       WIDTH  unsigned mixer sample
//     gate        1      high while at least one key is held
//     pwm_out     1      registered PWM pin
//     frame_start 1      one-clock pulse on the edge that begins a PWM frame
//     env         4      current envelope level 0..15
interface pwm_audio_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] sound;
    logic             gate;
    logic             pwm_out;
    logic             frame_start;
    logic [3:0]       env;

    modport master (
        output sound,
        output gate,
        input  pwm_out,
        input  frame_start,
        input  env
    );

    modport slave (
        input  sound,
        input  gate,
        output pwm_out,
        output frame_start,
        output env
    );
endinterface

// File: rtl/pwm_audio_out.sv
// pwm_audio_out
//   Output stage after the chord mixer. Scales the mixer sample by a 4-bit
//   attack/release envelope and produces a single-bit PWM stream for an
//   external RC filter. Sample, envelope and gate are only acted upon at frame
//   boundaries, so the input sample may change at any time without glitches.
//   Parameters:
//     WIDTH       sample width and PWM phase width (frame = 2^WIDTH ticks)
//     PRESC       clocks per PWM tick (>=1)
//     RAMP_FRAMES frames per envelope step (>=1)
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    pwm_audio_if slave: sound, gate in; pwm_out, frame_start, env out
module pwm_audio_out #(
    parameter int WIDTH       = 8,
    parameter int PRESC       = 1,
    parameter int RAMP_FRAMES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    pwm_audio_if.slave  bus
);

    localparam int PCNT_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int FCNT_W = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESC - 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(RAMP_FRAMES - 1);
    localparam logic [WIDTH-1:0]  PH_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } state_t;

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0]  ph_q, ph_d;
    logic [WIDTH-1:0]  duty_q, duty_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [3:0]        env_q, env_d;
    state_t            state_q, state_d;
    logic              pwm_out_q, pwm_out_d;
    logic              frame_start_q, frame_start_d;

    logic              tick;
    logic              fb;
    logic [WIDTH+3:0]  product;
    logic [3:0]        env_inc;
    logic [3:0]        env_dec;

    // Prescaler, phase counter, duty latch and PWM comparator.
    always_comb begin
        tick          = (pcnt_q == PCNT_MAX);
        fb            = tick && (ph_q == PH_MAX);
        pcnt_d        = tick ? '0 : pcnt_q + 1'b1;
        ph_d          = tick ? ph_q + 1'b1 : ph_q;
        // Full-precision product; dropping the low 4 bits makes env=15 map
        // to 15/16 of full scale.
        product       = {4'b0000, bus.sound} * {{WIDTH{1'b0}}, env_q};
        duty_d        = fb ? product[WIDTH+3:4] : duty_q;
        frame_start_d = fb;
        pwm_out_d     = (ph_q < duty_q);
    end

    // Saturating steps: ATTACK can be entered at env=15 (quick re-press
    // during release) and RELEASE at env=0 (quick release during attack),
    // so the step itself must never wrap.
    always_comb begin
        env_inc = (env_q == 4'd15) ? 4'd15 : env_q + 4'd1;
        env_dec = (env_q == 4'd0)  ? 4'd0  : env_q - 4'd1;
    end

    // Envelope FSM; only frame boundaries move it.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        fcnt_d  = fcnt_q;
        if (fb) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.gate) begin
                        state_d = ST_ATTACK;
                        fcnt_d  = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!bus.gate) begin
                        state_d = ST_RELEASE;
                        fcnt_d  = '0;
                    end else if (fcnt_q == FCNT_MAX) begin
                        env_d  = env_inc;
                        fcnt_d = '0;
                        if (env_inc == 4'd15) begin
                            state_d = ST_SUSTAIN;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                ST_SUSTAIN: begin
                    if (!bus.gate) begin
                        state_d = ST_RELEASE;
                        fcnt_d  = '0;
                    end
                end
                ST_RELEASE: begin
                    if (bus.gate) begin
                        state_d = ST_ATTACK;
                        fcnt_d  = '0;
                    end else if (fcnt_q == FCNT_MAX) begin
                        env_d  = env_dec;
                        fcnt_d = '0;
                        if (env_dec == 4'd0) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    env_d   = 4'd0;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q        <= '0;
            ph_q          <= '0;
            duty_q        <= '0;
            fcnt_q        <= '0;
            env_q         <= 4'd0;
            state_q       <= ST_IDLE;
            pwm_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pcnt_q        <= pcnt_d;
            ph_q          <= ph_d;
            duty_q        <= duty_d;
            fcnt_q        <= fcnt_d;
            env_q         <= env_d;
            state_q       <= state_d;
            pwm_out_q     <= pwm_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pwm_out     = pwm_out_q;
    assign bus.frame_start = frame_start_q;
    assign bus.env         = env_q;

endmodule

// File: tb/tb_pwm_audio_out.sv
// tb_pwm_audio_out
//   Directed bench for pwm_audio_out. Three instances cover the parameter
//   sets needed: A (PRESC=1, RAMP_FRAMES=1), B (PRESC=1, RAMP_FRAMES=4),
//   C (PRESC=3, RAMP_FRAMES=1). Expected values are hand-computed from the
//   frame/envelope rules: duty = (sound*env)>>4, high time = duty*PRESC.
module tb_pwm_audio_out;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    logic rst_n_c = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_audio_if #(.WIDTH(8)) if_a ();
    pwm_audio_if #(.WIDTH(8)) if_b ();
    pwm_audio_if #(.WIDTH(8)) if_c ();

    pwm_audio_out #(.WIDTH(8), .PRESC(1), .RAMP_FRAMES(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (if_a)
    );

    pwm_audio_out #(.WIDTH(8), .PRESC(1), .RAMP_FRAMES(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (if_b)
    );

    pwm_audio_out #(.WIDTH(8), .PRESC(3), .RAMP_FRAMES(1)) dut_c (
        .clk   (clk),
        .rst_n (rst_n_c),
        .bus   (if_c)
    );

    wire       fs_w  [3];
    wire       pwm_w [3];
    wire [3:0] env_w [3];

    assign fs_w[0]  = if_a.frame_start;
    assign fs_w[1]  = if_b.frame_start;
    assign fs_w[2]  = if_c.frame_start;
    assign pwm_w[0] = if_a.pwm_out;
    assign pwm_w[1] = if_b.pwm_out;
    assign pwm_w[2] = if_c.pwm_out;
    assign env_w[0] = if_a.env;
    assign env_w[1] = if_b.env;
    assign env_w[2] = if_c.env;

    task automatic set_rst(input int sel, input logic val);
        case (sel)
            0: rst_n_a = val;
            1: rst_n_b = val;
            default: rst_n_c = val;
        endcase
    endtask

    // Hold reset for three edges, release 1 time unit after an edge.
    task automatic do_reset(input int sel);
        set_rst(sel, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        set_rst(sel, 1'b1);
    endtask

    // Advance to the n-th next frame_start; edges = clocks to the last one.
    task automatic wait_fb(input int sel, input int n, output int edges);
        int cnt;
        edges = 0;
        for (int k = 0; k < n; k++) begin
            cnt = 0;
            do begin
                @(posedge clk);
                #1;
                cnt++;
            end while (!fs_w[sel] && cnt < 5000);
            edges = cnt;
            if (!fs_w[sel]) begin
                checks++;
                errors++;
                $display("FAIL fb_timeout dut%0d: no frame_start after %0d clks, required one", sel, cnt);
                return;
            end
        end
    endtask

    // From just after a frame boundary, count pwm high clocks up to and
    // including the next boundary edge.
    task automatic measure_frame(input int sel, output int highs, output int len);
        highs = 0;
        len   = 0;
        do begin
            @(posedge clk);
            #1;
            len++;
            if (pwm_w[sel]) highs++;
        end while (!fs_w[sel] && len < 5000);
    endtask

    task automatic test_reset();
        int cnt;
        if_a.sound = 8'd200;
        if_a.gate  = 1'b1;
        rst_n_a    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (if_a.pwm_out !== 1'b0 || if_a.env !== 4'd0 || if_a.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pwm=%b env=%0d fs=%b, required 0/0/0",
                     if_a.pwm_out, if_a.env, if_a.frame_start);
        end
        rst_n_a = 1'b1;
        repeat (100) @(posedge clk);
        #2;
        rst_n_a = 1'b0;
        #1;
        checks++;
        if (if_a.pwm_out !== 1'b0 || if_a.env !== 4'd0 || if_a.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_midframe: pwm=%b env=%0d fs=%b, required 0/0/0",
                     if_a.pwm_out, if_a.env, if_a.frame_start);
        end
        @(posedge clk);
        #1;
        rst_n_a = 1'b1;
        wait_fb(0, 1, cnt);
        checks++;
        if (cnt !== 256) begin
            errors++;
            $display("FAIL reset_first_fb: clks=%0d, required 256", cnt);
        end
        $display("test_reset: first frame_start %0d clks after release", cnt);
    endtask

    task automatic test_idle();
        int highs;
        int fbs;
        int env_bad;
        if_a.sound = 8'd255;
        if_a.gate  = 1'b0;
        do_reset(0);
        highs   = 0;
        fbs     = 0;
        env_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1;
            if (if_a.pwm_out) highs++;
            if (if_a.frame_start) fbs++;
            if (if_a.env !== 4'd0) env_bad++;
        end
        checks++;
        if (highs !== 0 || env_bad !== 0) begin
            errors++;
            $display("FAIL idle_output: highs=%0d env_nonzero=%0d, required 0/0", highs, env_bad);
        end
        checks++;
        if (fbs !== 4) begin
            errors++;
            $display("FAIL idle_frames: frame_starts=%0d, required 4", fbs);
        end
        $display("test_idle: highs=%0d frames=%0d", highs, fbs);
    endtask

    task automatic test_attack();
        int e;
        int highs;
        int len;
        if_a.sound = 8'd255;
        if_a.gate  = 1'b1;
        do_reset(0);
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd0) begin
            errors++;
            $display("FAIL attack_fb1: env=%0d, required 0", if_a.env);
        end
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd1) begin
            errors++;
            $display("FAIL attack_fb2: env=%0d, required 1", if_a.env);
        end
        wait_fb(0, 13, e);
        checks++;
        if (if_a.env !== 4'd14) begin
            errors++;
            $display("FAIL attack_fb15: env=%0d, required 14", if_a.env);
        end
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd15) begin
            errors++;
            $display("FAIL attack_fb16: env=%0d, required 15", if_a.env);
        end
        // Frame after FB16 uses env=14: (255*14)>>4 = 223.
        measure_frame(0, highs, len);
        checks++;
        if (highs !== 223 || len !== 256) begin
            errors++;
            $display("FAIL attack_frame16: highs=%0d len=%0d, required 223/256", highs, len);
        end
        // Frame after FB17 uses env=15: (255*15)>>4 = 239.
        measure_frame(0, highs, len);
        checks++;
        if (highs !== 239 || len !== 256) begin
            errors++;
            $display("FAIL attack_frame17: highs=%0d len=%0d, required 239/256", highs, len);
        end
        checks++;
        if (if_a.env !== 4'd15) begin
            errors++;
            $display("FAIL attack_sustain: env=%0d, required 15", if_a.env);
        end
        $display("test_attack: env=%0d max-duty highs=%0d", if_a.env, highs);
    endtask

    // Continues from SUSTAIN left by test_attack, sampled just after an FB.
    task automatic test_release();
        int e;
        int highs;
        int len;
        if_a.gate = 1'b0;
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd15) begin
            errors++;
            $display("FAIL release_enter: env=%0d, required 15", if_a.env);
        end
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd14) begin
            errors++;
            $display("FAIL release_step1: env=%0d, required 14", if_a.env);
        end
        wait_fb(0, 13, e);
        checks++;
        if (if_a.env !== 4'd1) begin
            errors++;
            $display("FAIL release_step14: env=%0d, required 1", if_a.env);
        end
        wait_fb(0, 1, e);
        checks++;
        if (if_a.env !== 4'd0) begin
            errors++;
            $display("FAIL release_step15: env=%0d, required 0", if_a.env);
        end
        // Latched with env=1 before the edge: (255*1)>>4 = 15.
        measure_frame(0, highs, len);
        checks++;
        if (highs !== 15) begin
            errors++;
            $display("FAIL release_last_frame: highs=%0d, required 15", highs);
        end
        measure_frame(0, highs, len);
        checks++;
        if (highs !== 0 || if_a.env !== 4'd0) begin
            errors++;
            $display("FAIL release_silent: highs=%0d env=%0d, required 0/0", highs, if_a.env);
        end
        $display("test_release: env=%0d silent-frame highs=%0d", if_a.env, highs);
    endtask

    task automatic test_reversal();
        int e;
        if_b.sound = 8'd255;
        if_b.gate  = 1'b1;
        do_reset(1);
        wait_fb(1, 20, e);
        checks++;
        if (if_b.env !== 4'd4) begin
            errors++;
            $display("FAIL reversal_fb20: env=%0d, required 4", if_b.env);
        end
        wait_fb(1, 1, e);
        checks++;
        if (if_b.env !== 4'd5) begin
            errors++;
            $display("FAIL reversal_fb21: env=%0d, required 5", if_b.env);
        end
        if_b.gate = 1'b0;
        wait_fb(1, 4, e);
        checks++;
        if (if_b.env !== 4'd5) begin
            errors++;
            $display("FAIL reversal_hold: env=%0d, required 5", if_b.env);
        end
        wait_fb(1, 1, e);
        checks++;
        if (if_b.env !== 4'd4) begin
            errors++;
            $display("FAIL reversal_drop: env=%0d, required 4", if_b.env);
        end
        if_b.gate = 1'b1;
        wait_fb(1, 4, e);
        checks++;
        if (if_b.env !== 4'd4) begin
            errors++;
            $display("FAIL reversal_reattack_hold: env=%0d, required 4", if_b.env);
        end
        wait_fb(1, 1, e);
        checks++;
        if (if_b.env !== 4'd5) begin
            errors++;
            $display("FAIL reversal_reattack_rise: env=%0d, required 5", if_b.env);
        end
        $display("test_reversal: env=%0d", if_b.env);
    endtask

    task automatic test_prescaler();
        int e;
        int highs;
        int len;
        if_c.sound = 8'd128;
        if_c.gate  = 1'b1;
        do_reset(2);
        wait_fb(2, 1, e);
        checks++;
        if (e !== 768) begin
            errors++;
            $display("FAIL presc_first_fb: clks=%0d, required 768", e);
        end
        wait_fb(2, 15, e);
        checks++;
        if (if_c.env !== 4'd15 || e !== 768) begin
            errors++;
            $display("FAIL presc_fb16: env=%0d spacing=%0d, required 15/768", if_c.env, e);
        end
        // env=14 latched: (128*14)>>4 = 112 -> 336 clks.
        measure_frame(2, highs, len);
        checks++;
        if (highs !== 336 || len !== 768) begin
            errors++;
            $display("FAIL presc_frame16: highs=%0d len=%0d, required 336/768", highs, len);
        end
        measure_frame(2, highs, len);
        checks++;
        if (highs !== 360 || len !== 768) begin
            errors++;
            $display("FAIL presc_frame17: highs=%0d len=%0d, required 360/768", highs, len);
        end
        // Change sound inside a high period; the running frame must keep 360.
        highs = 0;
        len   = 0;
        do begin
            @(posedge clk);
            #1;
            len++;
            if (if_c.pwm_out) highs++;
            if (len == 100) if_c.sound = 8'd16;
        end while (!if_c.frame_start && len < 5000);
        checks++;
        if (highs !== 360 || len !== 768) begin
            errors++;
            $display("FAIL presc_hold: highs=%0d len=%0d, required 360/768", highs, len);
        end
        // (16*15)>>4 = 15 -> 45 clks.
        measure_frame(2, highs, len);
        checks++;
        if (highs !== 45 || len !== 768) begin
            errors++;
            $display("FAIL presc_new_sample: highs=%0d len=%0d, required 45/768", highs, len);
        end
        $display("test_prescaler: last frame highs=%0d len=%0d", highs, len);
    endtask

    initial begin
        if_a.sound = '0;
        if_a.gate  = 1'b0;
        if_b.sound = '0;
        if_b.gate  = 1'b0;
        if_c.sound = '0;
        if_c.gate  = 1'b0;
        test_reset();
        test_idle();
        test_attack();
        test_release();
        test_reversal();
        test_prescaler();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
